message_reverse_buffer: RTL and testbench
=========================================

Name: message_reverse_buffer

Overview:
Parametrised byte-capture and replay buffer between the keyboard/serial-RX byte stream and the message printer / serial TX path. It collects up to DEPTH bytes. When the buffer fills, or an explicit end-of-message arrives, it replays the message in reverse (or forward) order, followed by an optional LF/CR terminator. It adds valid/ready handshakes on both sides, variable message length and backpressure.

Parameters:
DEPTH, 3, maximum stored message bytes; legal range 1..64
REVERSE, 1, 1 = replay last-in first; 0 = replay in arrival order
ADD_TERM, 1, 1 = append LF (0x0A) then CR (0x0D) after the data bytes; 0 = no terminator
CNT_W, $clog2(DEPTH+1), counter width (derived; do not override)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_data  in  8  incoming byte
in_valid  in  1  in_data valid this cycle
in_ready  out  1  buffer accepts a byte this cycle
flush  in  1  end-of-message request (e.g. Enter key)
out_data  out  8  byte to printer/TX
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data this cycle
msg_len  out  CNT_W  number of bytes currently stored
busy  out  1  high while replaying (DRAIN or TERM states)

Behaviour:
- Reset (rst=1 at posedge): state=FILL, count=0, rd_idx=0, term_sel=0, out_valid=0, out_data=0x00, in_ready=1 after reset, busy=0, msg_len=0. Storage array contents are don't-care and are not reset.
- States: FILL, DRAIN, TERM.
- FILL:
  - in_ready = 1.
  - A byte is accepted when in_valid && in_ready: mem[count] <= in_data; count++.
  - Go to DRAIN when (accept && count+1==DEPTH) or (flush && (count>0 || accept)).
  - flush and in_valid in the same cycle: the byte is stored first and is included in the replay.
  - flush with count==0 and no accept: ignored; stay in FILL; no output.
  - No accept is possible at count==DEPTH, because the state has already left FILL.
- DRAIN entry:
  - REVERSE=1: rd_idx = final_count-1.
  - REVERSE=0: rd_idx = 0.
  - out_valid rises the cycle after the transition edge; latency from the final accept/flush edge to first out_valid is 1 cycle.
- DRAIN:
  - in_ready = 0; in_valid is ignored (bytes dropped, no error).
  - out_valid = 1; out_data = mem[rd_idx], registered, and held stable while out_ready=0.
  - On out_valid && out_ready, advance rd_idx: down for REVERSE=1, up for REVERSE=0.
  - After the last byte transfers: if ADD_TERM go to TERM, else go to FILL with count=0.
  - No bubble between bytes when out_ready is held high: one byte per cycle.
- TERM:
  - out_data = 0x0A, then 0x0D, each held until its handshake.
  - After the 0x0D transfer, go to FILL with count=0; out_valid=0 the next cycle.
- flush during DRAIN or TERM: ignored.
- rst mid-DRAIN or mid-TERM: out_valid drops at the reset edge, count returns to 0, and the partial message is discarded.
- msg_len reflects count. It holds the captured length throughout DRAIN/TERM and clears when FILL is re-entered.
- busy = (state != FILL).
- Arithmetic:
  - rd_idx and count are CNT_W-bit unsigned.
  - The rd_idx decrement never wraps below 0, because the last-byte check uses rd_idx==0 (REVERSE=1) or rd_idx==count-1 (REVERSE=0).

Decomposition:
- Shared package msg_pkg holds:
  - state enum {FILL, DRAIN, TERM}
  - constants ASCII_LF=8'h0A and ASCII_CR=8'h0D
  - ASCII_SPACE=8'h20, kept for the printer's idle fill
- Natural sub-module: msg_byte_store. It is a DEPTH x 8 register array with a write port (we, waddr, wdata) and a registered read port (raddr → rdata). The top module keeps the FSM, counters and handshakes.

Test Plan:
- DEPTH=3, REVERSE=1, ADD_TERM=1, out_ready=1: write 'a','b','c' (0x61,0x62,0x63) → out stream 0x63,0x62,0x61,0x0A,0x0D on consecutive cycles; in_ready=0 for those 5 cycles; then in_ready=1 and msg_len=0.
- DEPTH=8: write 0x31,0x32, then flush alone → 0x32,0x31,0x0A,0x0D; msg_len=2 during replay.
- Backpressure: as the first scenario, but hold out_ready=0 for 4 cycles after out_valid rises → out_data stays 0x63 and no byte is lost or duplicated; the full sequence then completes.
- Simultaneous: DEPTH=8, write 0x41; then 0x42 with flush in the same cycle → 0x42,0x41,0x0A,0x0D. Flush on an empty buffer → no out_valid for 10 cycles.
- REVERSE=0, ADD_TERM=0, DEPTH=4: write 0x10..0x13 → 0x10,0x11,0x12,0x13, then FILL. in_valid pulses during DRAIN are dropped: the next message starts at mem[0].
- Reset mid-DRAIN, after the first byte transfers: out_valid=0, in_ready=1 and msg_len=0 after the reset edge. A new message 0x55 + flush → 0x55,0x0A,0x0D only.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and constants for the message reverse buffer.
// Included by the byte store and the replay controller.
package msg_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    TERM  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Address width for a store of the given depth, never zero
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/msg_byte_store.sv
// Byte array with one write port and a registered read port.
// A same-cycle write to the read address is forwarded to rdata.
module msg_byte_store
  import msg_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  // Storage write; contents are not reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read with write-first forwarding
  always_ff @(posedge clk) begin
    if (rst_i)
      rdata_q <= 8'h00;
    else if (we_i && (waddr_i == raddr_i))
      rdata_q <= wdata_i;
    else
      rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/message_reverse_buffer.sv
// Captures up to DEPTH bytes, then replays them reversed or in
// order, optionally followed by LF and CR.
module message_reverse_buffer
  import msg_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REVERSE  = 1,
  parameter int ADD_TERM = 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] msg_len,
  output logic             busy
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic             tsel_q, tsel_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic             fire;
  logic             last_rd;
  logic [CNT_W-1:0] fin_cnt;
  logic [7:0]       rdata;

  assign accept  = (state_q == FILL) && in_valid;
  assign fire    = ov_q && out_ready;
  assign fin_cnt = cnt_q + CNT_W'(accept);
  assign last_rd = (REVERSE != 0) ? (rd_q == '0)
                                  : (rd_q == cnt_q - ONE_C);

  msg_byte_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .rst_i   (rst),
    .we_i    (accept),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_d[AW-1:0]),
    .rdata_o (rdata)
  );

  // Next-state: capture, replay index walk, terminator sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    tsel_d  = tsel_q;
    ov_d    = ov_q;
    unique case (state_q)
      FILL: begin
        if (accept) cnt_d = fin_cnt;
        if ((accept && cnt_q == LAST_C) ||
            (flush && fin_cnt != '0)) begin
          state_d = DRAIN;
          ov_d    = 1'b1;
          rd_d    = (REVERSE != 0) ? fin_cnt - ONE_C : '0;
        end
      end
      DRAIN: begin
        if (fire) begin
          if (!last_rd) begin
            rd_d = (REVERSE != 0) ? rd_q - ONE_C : rd_q + ONE_C;
          end else if (ADD_TERM != 0) begin
            state_d = TERM;
            tsel_d  = 1'b0;
          end else begin
            state_d = FILL;
            ov_d    = 1'b0;
            cnt_d   = '0;
            rd_d    = '0;
          end
        end
      end
      TERM: begin
        if (fire) begin
          if (!tsel_q) begin
            tsel_d = 1'b1;
          end else begin
            state_d = FILL;
            ov_d    = 1'b0;
            cnt_d   = '0;
            rd_d    = '0;
            tsel_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = FILL;
        ov_d    = 1'b0;
      end
    endcase
  end

  // Controller state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      rd_q    <= '0;
      tsel_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      tsel_q  <= tsel_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q != FILL);
  assign out_valid = ov_q;
  assign msg_len   = cnt_q;
  assign out_data  = (state_q == TERM) ? (tsel_q ? ASCII_CR : ASCII_LF)
                                       : rdata;

endmodule

// File: tb/tb_message_reverse_buffer.sv
// Randomized and directed bench for message_reverse_buffer.
// Three instances cover reverse/forward and terminator options.
module tb_message_reverse_buffer;

  localparam int DEP [3] = '{3, 8, 4};
  localparam int REV [3] = '{1, 1, 0};
  localparam int TRM [3] = '{1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [3];
  logic [7:0] idat [3];
  logic       iv   [3];
  logic       fl   [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic       bz   [3];
  logic [7:0] od   [3];
  logic [1:0] ml0;
  logic [3:0] ml1;
  logic [2:0] ml2;

  int n_run  = 0;
  int n_fail = 0;

  message_reverse_buffer #(
    .DEPTH(3), .REVERSE(1), .ADD_TERM(1)
  ) u0 (
    .clk(clk), .rst(rst[0]), .in_data(idat[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .flush(fl[0]),
    .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .msg_len(ml0), .busy(bz[0])
  );

  message_reverse_buffer #(
    .DEPTH(8), .REVERSE(1), .ADD_TERM(1)
  ) u1 (
    .clk(clk), .rst(rst[1]), .in_data(idat[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .flush(fl[1]),
    .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .msg_len(ml1), .busy(bz[1])
  );

  message_reverse_buffer #(
    .DEPTH(4), .REVERSE(0), .ADD_TERM(0)
  ) u2 (
    .clk(clk), .rst(rst[2]), .in_data(idat[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .flush(fl[2]),
    .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .msg_len(ml2), .busy(bz[2])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mlen(input int k);
    case (k)
      0:       return int'(ml0);
      1:       return int'(ml1);
      default: return int'(ml2);
    endcase
  endfunction

  // Reference model: a message is the list of accepted bytes;
  // once it ends, the expected output list is built from it.
  logic [7:0] sbuf [3][64];
  logic [7:0] ebuf [3][72];
  int scnt [3] = '{0, 0, 0};
  int eh   [3] = '{0, 0, 0};
  int et   [3] = '{0, 0, 0};
  bit mb   [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        mb[k] = 0; scnt[k] = 0; eh[k] = 0; et[k] = 0;
      end else if (!mb[k]) begin
        bit acc;
        acc = iv[k];
        if (acc) begin
          sbuf[k][scnt[k]] = idat[k];
          scnt[k]++;
        end
        if ((acc && scnt[k] == DEP[k]) || (fl[k] && scnt[k] > 0)) begin
          int n;
          n = scnt[k];
          for (int i = 0; i < n; i++)
            ebuf[k][i] = REV[k] ? sbuf[k][n-1-i] : sbuf[k][i];
          et[k] = n;
          if (TRM[k]) begin
            ebuf[k][n]   = 8'h0A;
            ebuf[k][n+1] = 8'h0D;
            et[k] = n + 2;
          end
          eh[k] = 0;
          mb[k] = 1;
        end
      end else if (ordy[k]) begin
        eh[k]++;
        if (eh[k] == et[k]) begin
          mb[k] = 0;
          scnt[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.in_ready", k), int'(ir[k]), int'(!mb[k]));
      chk($sformatf("u%0d.out_valid", k), int'(ov[k]), int'(mb[k]));
      chk($sformatf("u%0d.busy", k), int'(bz[k]), int'(mb[k]));
      chk($sformatf("u%0d.msg_len", k), mlen(k), scnt[k]);
      if (mb[k])
        chk($sformatf("u%0d.out_data", k), int'(od[k]), int'(ebuf[k][eh[k]]));
    end
  end

  task automatic cyc(input int k, input bit v, input logic [7:0] d,
                     input bit f, input bit r);
    @(negedge clk);
    #1;
    iv[k] = v; idat[k] = d; fl[k] = f; ordy[k] = r;
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      cyc(k, 1'b0, 8'h00, 1'b0, 1'b1);
      if (!mb[k]) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("u%0d.drain_done", k), int'(ok), 1);
  endtask

  task automatic rst_pulse(input int k);
    @(negedge clk);
    #1;
    rst[k] = 1'b1;
    iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("u%0d.rst_out_data", k), int'(od[k]), 0);
    chk($sformatf("u%0d.rst_out_valid", k), int'(ov[k]), 0);
    #1;
    rst[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; idat[k] = 8'h00; iv[k] = 1'b0;
      fl[k] = 1'b0; ordy[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d.reset_out_data", k), int'(od[k]), 0);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // full buffer, reverse with terminator
    cyc(0, 1'b1, 8'h61, 1'b0, 1'b1);
    cyc(0, 1'b1, 8'h62, 1'b0, 1'b1);
    cyc(0, 1'b1, 8'h63, 1'b0, 1'b1);
    wait_idle(0);

    // backpressure on the first byte
    cyc(0, 1'b1, 8'h61, 1'b0, 1'b1);
    cyc(0, 1'b1, 8'h62, 1'b0, 1'b1);
    cyc(0, 1'b1, 8'h63, 1'b0, 1'b1);
    repeat (4) cyc(0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("u0.bp_hold", int'(od[0]), 8'h63);
    wait_idle(0);

    // short message ended by flush alone
    cyc(1, 1'b1, 8'h31, 1'b0, 1'b1);
    cyc(1, 1'b1, 8'h32, 1'b0, 1'b1);
    cyc(1, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_idle(1);

    // flush together with the final byte
    cyc(1, 1'b1, 8'h41, 1'b0, 1'b1);
    cyc(1, 1'b1, 8'h42, 1'b1, 1'b1);
    wait_idle(1);

    // flush on an empty buffer must produce nothing
    cyc(1, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (10) cyc(1, 1'b0, 8'h00, 1'b0, 1'b1);

    // forward order, no terminator, input pulses while draining
    cyc(2, 1'b1, 8'h10, 1'b0, 1'b1);
    cyc(2, 1'b1, 8'h11, 1'b0, 1'b1);
    cyc(2, 1'b1, 8'h12, 1'b0, 1'b1);
    cyc(2, 1'b1, 8'h13, 1'b0, 1'b1);
    cyc(2, 1'b1, 8'hEE, 1'b0, 1'b1);
    cyc(2, 1'b1, 8'hEF, 1'b1, 1'b1);
    wait_idle(2);
    cyc(2, 1'b1, 8'h20, 1'b0, 1'b1);
    cyc(2, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_idle(2);

    // reset after the first replayed byte
    cyc(0, 1'b1, 8'h61, 1'b0, 1'b1);
    cyc(0, 1'b1, 8'h62, 1'b0, 1'b1);
    cyc(0, 1'b1, 8'h63, 1'b0, 1'b1);
    cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);
    rst_pulse(0);
    cyc(0, 1'b1, 8'h55, 1'b1, 1'b1);
    wait_idle(0);

    // random traffic with random flush and backpressure
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 400; n++)
        cyc(k, 1'($urandom % 2), 8'($urandom),
            ($urandom % 8) == 0, ($urandom % 4) != 0);
      wait_idle(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
